// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry / MRET sequencer.
// Owns mstatus, mie, mtvec, mepc, mcause and mtval. Issues one PC redirect per
// accepted trap or MRET and holds it until fetch accepts it.
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_ExceptionRaised,
    input  logic        i_Interrupt,
    input  logic [3:0]  i_ExceptionCause,
    input  logic [31:0] i_TrapPc,
    input  logic [31:0] i_TrapValue,
    input  logic        i_Mret,
    input  logic [11:0] i_CsrAddress,
    input  logic        i_CsrWriteEnable,
    input  logic [31:0] i_CsrWriteData,
    output logic [31:0] o_CsrReadData,
    output logic        o_ExternalIntEnable,
    output logic        o_SoftwareIntEnable,
    output logic        o_TimerIntEnable,
    output logic        o_Busy,
    output logic        o_RedirectValid,
    output logic [31:0] o_RedirectPc,
    input  logic        i_RedirectReady
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Only MEIE (11), MTIE (7) and MSIE (3) exist in mie.
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    state_t      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        trap_accept;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    // Interrupts only enter when globally enabled; synchronous exceptions always do.
    assign trap_accept = i_ExceptionRaised && (!i_Interrupt || mstatus_mie_q);
    assign trap_base   = {mtvec_q[31:2], 2'b00};
    assign trap_target = (mtvec_q[0] && i_Interrupt)
                       ? trap_base + {26'b0, i_ExceptionCause, 2'b00}
                       : trap_base;

    assign o_Busy              = (state_q == REDIRECT);
    assign o_RedirectValid     = (state_q == REDIRECT);
    assign o_RedirectPc        = redirect_pc_q;
    assign o_ExternalIntEnable = mstatus_mie_q & mie_q[11];
    assign o_SoftwareIntEnable = mstatus_mie_q & mie_q[3];
    assign o_TimerIntEnable    = mstatus_mie_q & mie_q[7];

    // Combinational CSR read; returns pre-write values during a same-cycle write.
    always_comb begin
        o_CsrReadData = 32'h0;
        case (i_CsrAddress)
            CSR_MSTATUS: o_CsrReadData = {19'b0, 2'b11, 3'b0, mstatus_mpie_q,
                                          3'b0, mstatus_mie_q, 3'b0};
            CSR_MIE:     o_CsrReadData = mie_q;
            CSR_MTVEC:   o_CsrReadData = mtvec_q;
            CSR_MEPC:    o_CsrReadData = mepc_q;
            CSR_MCAUSE:  o_CsrReadData = mcause_q;
            CSR_MTVAL:   o_CsrReadData = mtval_q;
            default:     o_CsrReadData = 32'h0;
        endcase
    end

    // Next-state: trap entry beats MRET beats CSR write; REDIRECT ignores them all.
    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        redirect_pc_d  = redirect_pc_q;

        case (state_q)
            IDLE: begin
                if (trap_accept) begin
                    mepc_d         = {i_TrapPc[31:2], 2'b00};
                    mcause_d       = {i_Interrupt, 27'b0, i_ExceptionCause};
                    mtval_d        = i_Interrupt ? 32'h0 : i_TrapValue;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    redirect_pc_d  = trap_target;
                    state_d        = REDIRECT;
                end else if (i_Mret) begin
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                    redirect_pc_d  = mepc_q;
                    state_d        = REDIRECT;
                end else if (i_CsrWriteEnable) begin
                    case (i_CsrAddress)
                        CSR_MSTATUS: begin
                            mstatus_mie_d  = i_CsrWriteData[3];
                            mstatus_mpie_d = i_CsrWriteData[7];
                        end
                        CSR_MIE:    mie_d    = i_CsrWriteData & MIE_MASK;
                        CSR_MTVEC:  mtvec_d  = {i_CsrWriteData[31:2], 1'b0, i_CsrWriteData[0]};
                        CSR_MEPC:   mepc_d   = {i_CsrWriteData[31:2], 2'b00};
                        CSR_MCAUSE: mcause_d = {i_CsrWriteData[31], 27'b0, i_CsrWriteData[3:0]};
                        CSR_MTVAL:  mtval_d  = i_CsrWriteData;
                        default: ;
                    endcase
                end
            end
            REDIRECT: begin
                if (i_RedirectReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and CSR registers with synchronous active-high reset.
    always_ff @(posedge i_Clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_Reset) begin
            state_q        <= IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0;
            mtvec_q        <= MTVEC_RESET;
            mepc_q         <= 32'h0;
            mcause_q       <= 32'h0;
            mtval_q        <= 32'h0;
            redirect_pc_q  <= 32'h0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

endmodule
